// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative multiply/divide unit for the EX stage.
// Accepts MULT/MULTU/DIV/DIVU from ID/EX and produces a 2*WIDTH result
// into HI/LO after WIDTH+1 edges. The pipeline is held through stall_o.
//
// Ports:
//   clk_i       clock, all state on posedge
//   rst_i       synchronous active-high reset
//   start_i     valid mul/div op this cycle
//   op_i        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a_i     multiplicand / dividend
//   src_b_i     multiplier / divisor
//   flush_i     abort the in-flight op
//   busy_o      op in progress
//   stall_o     hold upstream (busy or op being accepted)
//   done_o      one-cycle pulse when HI/LO are written
//   div_zero_o  pulses with done_o for a zero divisor
//   hi_o/lo_o   HI (product high / remainder), LO (product low / quotient)
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e             r_state;
  logic [CntW-1:0]    r_cnt;
  logic               r_busy, r_done, r_div_zero;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_is_div, r_a_neg, r_b_neg, r_dz;
  // Magnitudes of signed operands fit unsigned in WIDTH bits, including
  // the most-negative value.
  logic [WIDTH-1:0]   r_a_mag, r_b_mag;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, remaining dividend bits / quotient bits}.
  logic [2*WIDTH-1:0] r_acc;

  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH+1:0]   w_div_trial;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem, w_a_orig, w_fix_hi, w_fix_lo;
  logic               w_unused;

  always_comb begin
    w_a_mag = (!op_i[0] && src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
    w_b_mag = (!op_i[0] && src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;

    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a_mag} : '0);
    w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring division: shift in the next dividend bit, try subtracting.
    w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_div_trial = {1'b0, w_div_shift} - {2'b00, r_b_mag};
    if (w_div_trial[WIDTH+1]) begin
      w_div_next = {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end else begin
      w_div_next = {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end
    // A successful trial is always below the divisor, so its top bit is 0.
    w_unused = w_div_trial[WIDTH];

    w_prod   = (r_a_neg ^ r_b_neg) ? -r_acc : r_acc;
    w_quo    = (r_a_neg ^ r_b_neg) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem    = r_a_neg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    w_a_orig = r_a_neg ? -r_a_mag : r_a_mag;

    if (!r_is_div) begin
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
    end else if (r_dz) begin
      w_fix_hi = w_a_orig;
      w_fix_lo = '1;
    end else begin
      w_fix_hi = w_rem;
      w_fix_lo = w_quo;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_is_div   <= 1'b0;
      r_a_neg    <= 1'b0;
      r_b_neg    <= 1'b0;
      r_dz       <= 1'b0;
      r_a_mag    <= '0;
      r_b_mag    <= '0;
      r_acc      <= '0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start_i && !flush_i) begin
            r_is_div <= op_i[1];
            r_a_neg  <= !op_i[0] && src_a_i[WIDTH-1];
            r_b_neg  <= !op_i[0] && src_b_i[WIDTH-1];
            r_dz     <= op_i[1] && (src_b_i == '0);
            r_a_mag  <= w_a_mag;
            r_b_mag  <= w_b_mag;
            r_acc    <= op_i[1] ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= StCalc;
          end
        end
        StCalc: begin
          if (flush_i) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + CntW'(1);
            if (r_cnt == CntW'(WIDTH - 1)) begin
              r_state <= StFix;
            end
          end
        end
        StFix: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
          if (!flush_i) begin
            r_hi       <= w_fix_hi;
            r_lo       <= w_fix_lo;
            r_done     <= 1'b1;
            r_div_zero <= r_dz;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy_o     = r_busy;
  assign stall_o    = r_busy | (start_i & (r_state == StIdle) & ~flush_i);
  assign done_o     = r_done;
  assign div_zero_o = r_div_zero;
  assign hi_o       = r_hi;
  assign lo_o       = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: stimulus pushes expected HI/LO,
// divide-by-zero flag and done cycle; a negedge monitor pops on done_o.
module tb_ex_muldiv_unit;

  localparam logic [1:0] OpMult = 2'b00, OpMultu = 2'b01, OpDiv = 2'b10, OpDivu = 2'b11;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] src_a_i = '0;
  logic [31:0] src_b_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o, stall_o, done_o, div_zero_o;
  logic [31:0] hi_o, lo_o;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .src_a_i    (src_a_i),
    .src_b_i    (src_b_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .div_zero_o (div_zero_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every done_o pulse against the oldest expectation.
  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done_o), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi", 64'(hi_o), 64'(e.hi));
        check("lo", 64'(lo_o), 64'(e.lo));
        check("div_zero", 64'(div_zero_o), 64'(e.dz));
        check("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edz);
    start_i = 1'b1;
    op_i    = op;
    src_a_i = a;
    src_b_i = b;
    #1 check("stall_on_start", 64'(stall_o), 64'(1));
    @(negedge clk_i);
    start_i = 1'b0;
    check("busy_after_start", 64'(busy_o), 64'(1));
    if (push) sb.push_back('{ehi, elo, edz, cyc + 33});
  endtask

  task automatic drain();
    for (int t = 0; t < 80 && sb.size() != 0; t++) @(negedge clk_i);
    check("drain", 64'(sb.size()), 64'(0));
    @(negedge clk_i);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    check("rst_hi", 64'(hi_o), 64'(0));
    check("rst_lo", 64'(lo_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_stall", 64'(stall_o), 64'(0));
    rst_i = 1'b0;
    @(negedge clk_i);

    issue(OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 1'b0); drain();
    issue(OpMult,  32'hFFFFFFFD, 32'd5,        1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0); drain();
    issue(OpMult,  32'h80000000, 32'h80000000, 1, 32'h40000000, 32'h00000000, 1'b0); drain();
    issue(OpDiv,   32'hFFFFFFF9, 32'd2,        1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0); drain();
    issue(OpDivu,  32'd7,        32'd0,        1, 32'd7,        32'hFFFFFFFF, 1'b1); drain();
    issue(OpDiv,   32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, 1'b0); drain();
    issue(OpDiv,   32'hFFFFFFFB, 32'd0,        1, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1); drain();
    issue(OpDivu,  32'd100,      32'd7,        1, 32'd2,        32'd14,       1'b0); drain();

    // Flush together with start in IDLE: not accepted.
    start_i = 1'b1; flush_i = 1'b1; op_i = OpMultu; src_a_i = 32'd3; src_b_i = 32'd3;
    #1 check("stall_flush_idle", 64'(stall_o), 64'(0));
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b0;
    check("busy_flush_idle", 64'(busy_o), 64'(0));

    // Flush mid-CALC: no done, HI/LO keep previous result.
    issue(OpMultu, 32'd3, 32'd4, 0, '0, '0, 1'b0);
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("busy_after_flush", 64'(busy_o), 64'(0));
    repeat (40) @(negedge clk_i);
    check("hi_kept_flush", 64'(hi_o), 64'(2));
    check("lo_kept_flush", 64'(lo_o), 64'(14));

    // Second start while busy is ignored; HI/LO stable while busy.
    issue(OpDivu, 32'd1000, 32'd10, 1, 32'd0, 32'd100, 1'b0);
    repeat (5) @(negedge clk_i);
    start_i = 1'b1; op_i = OpMultu; src_a_i = 32'd2; src_b_i = 32'd2;
    #1 check("stall_busy", 64'(stall_o), 64'(1));
    @(negedge clk_i);
    start_i = 1'b0;
    check("busy_mid", 64'(busy_o), 64'(1));
    check("hi_stable_busy", 64'(hi_o), 64'(2));
    check("lo_stable_busy", 64'(lo_o), 64'(14));
    drain();

    // Back-to-back: new start on the done_o cycle.
    issue(OpMult, 32'd7, 32'hFFFFFFFA, 1, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0);
    for (int t = 0; t < 60 && !done_o; t++) @(negedge clk_i);
    check("b2b_done_seen", 64'(done_o), 64'(1));
    issue(OpDivu, 32'd9, 32'd3, 1, 32'd0, 32'd3, 1'b0);
    drain();

    // Reset mid-CALC, then a fresh op completes.
    issue(OpMultu, 32'd5, 32'd5, 0, '0, '0, 1'b0);
    repeat (10) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_hi", 64'(hi_o), 64'(0));
    check("midrst_lo", 64'(lo_o), 64'(0));
    check("midrst_busy", 64'(busy_o), 64'(0));
    check("midrst_done", 64'(done_o), 64'(0));
    rst_i = 1'b0;
    @(negedge clk_i);
    issue(OpDivu, 32'd9, 32'd2, 1, 32'd1, 32'd4, 1'b0);
    drain();

    repeat (5) @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
